// File: rtl/shared_unit_arbiter_if.sv
// Requester, shared-unit and response signals of the shared-unit arbiter.
// slave is the arbiter's view; master is the parent/test side.
interface shared_unit_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 5
);
    localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    // Response handshake: a response transfers on any rising edge where
    // rsp_valid and rsp_ready are both high.  Once rsp_valid rises,
    // rsp_id and rsp_data hold until that edge, and rsp_valid does not
    // depend on rsp_ready.
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       grant;
    logic                  unit_start;
    logic [WIDTH-1:0]      unit_in;
    logic [WIDTH-1:0]      unit_out;
    logic                  rsp_valid;
    logic [ID_W-1:0]       rsp_id;
    logic [WIDTH-1:0]      rsp_data;
    logic                  rsp_ready;

    modport slave (
        input  req, req_data, unit_out, rsp_ready,
        output grant, unit_start, unit_in, rsp_valid, rsp_id, rsp_data
    );

    modport master (
        output req, req_data, unit_out, rsp_ready,
        input  grant, unit_start, unit_in, rsp_valid, rsp_id, rsp_data
    );
endinterface

// File: rtl/shared_unit_arbiter.sv
// Round-robin arbiter that time-shares one fixed-latency compute unit among
// NREQ requesters, one transaction at a time, and returns results over valid/ready.
module shared_unit_arbiter #(
    parameter int NREQ    = 4,
    parameter int WIDTH   = 5,
    parameter int LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    shared_unit_arbiter_if.slave  bus,
    output logic [1:0]            state_dbg
);
    localparam int ID_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   ptr_q, id_q, rsp_id_q;
    logic [WIDTH-1:0]  operand_q, rsp_data_q;
    logic [CNT_W-1:0]  cnt_q;

    logic [2*NREQ-1:0] req_dbl, req_shift;
    logic [NREQ-1:0]   req_rot;
    logic [ID_W:0]     win_off, win_sum, ptr_sum;
    logic [ID_W-1:0]   win_id, ptr_next;
    logic [WIDTH-1:0]  win_data;
    logic              found, arb_edge, arb_fire, first_busy, last_busy;

    // Rotate requests so bit 0 is the requester at ptr; the lowest set bit
    // of the rotated vector is then the round-robin winner's offset from ptr.
    always_comb begin
        req_dbl   = {bus.req, bus.req};
        req_shift = req_dbl >> ptr_q;
        req_rot   = req_shift[NREQ-1:0];
        found     = 1'b0;
        win_off   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                found   = 1'b1;
                win_off = (ID_W+1)'(i);
            end
        end
        win_sum = {1'b0, ptr_q} + win_off;
        if (win_sum >= (ID_W+1)'(NREQ)) win_sum = win_sum - (ID_W+1)'(NREQ);
        win_id  = win_sum[ID_W-1:0];
        ptr_sum = {1'b0, win_id} + (ID_W+1)'(1);
        if (ptr_sum >= (ID_W+1)'(NREQ)) ptr_sum = '0;
        ptr_next = ptr_sum[ID_W-1:0];
        win_data = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (win_id == ID_W'(k)) win_data = bus.req_data[k*WIDTH +: WIDTH];
        end
    end

    assign arb_edge   = (state_q == IDLE) || ((state_q == RESP) && bus.rsp_ready);
    assign arb_fire   = arb_edge && found;
    assign first_busy = (state_q == BUSY) && (cnt_q == CNT_W'(LATENCY));
    assign last_busy  = (state_q == BUSY) && (cnt_q == CNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = found ? BUSY : IDLE;
            BUSY:    state_d = last_busy ? RESP : BUSY;
            RESP:    if (bus.rsp_ready) state_d = found ? BUSY : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Transaction context and result capture; no arithmetic on the data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q      <= '0;
            id_q       <= '0;
            operand_q  <= '0;
            cnt_q      <= '0;
            rsp_id_q   <= '0;
            rsp_data_q <= '0;
        end else if (arb_fire) begin
            ptr_q     <= ptr_next;
            id_q      <= win_id;
            operand_q <= win_data;
            cnt_q     <= CNT_W'(LATENCY);
        end else if (state_q == BUSY) begin
            cnt_q <= cnt_q - CNT_W'(1);
            if (last_busy) begin
                rsp_id_q   <= id_q;
                rsp_data_q <= bus.unit_out;
            end
        end
    end

    always_comb begin
        bus.grant      = first_busy ? (NREQ'(1) << id_q) : '0;
        bus.unit_start = first_busy;
        bus.unit_in    = (state_q == BUSY) ? operand_q : '0;
        bus.rsp_valid  = (state_q == RESP);
        bus.rsp_id     = rsp_id_q;
        bus.rsp_data   = rsp_data_q;
        state_dbg      = state_q;
    end
endmodule

// File: tb/tb_shared_unit_arbiter.sv
// Directed bench for shared_unit_arbiter: a LATENCY=2 and a LATENCY=15
// instance, each driving an increment unit (unit_in + 1, wrapping at 32).
module tb_shared_unit_arbiter;
    logic       clk;
    logic       rst_n;
    logic [1:0] state_dbg, state15_dbg;
    int         checks = 0;
    int         errors = 0;

    shared_unit_arbiter_if #(.NREQ(4), .WIDTH(5)) bus ();
    shared_unit_arbiter_if #(.NREQ(4), .WIDTH(5)) bus15 ();

    assign bus.unit_out   = bus.unit_in + 5'd1;
    assign bus15.unit_out = bus15.unit_in + 5'd1;

    shared_unit_arbiter #(.NREQ(4), .WIDTH(5), .LATENCY(2)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave), .state_dbg(state_dbg)
    );

    shared_unit_arbiter #(.NREQ(4), .WIDTH(5), .LATENCY(15)) dut15 (
        .clk(clk), .rst_n(rst_n), .bus(bus15.slave), .state_dbg(state15_dbg)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        bus.req = '0;
        bus15.req = '0;
        step();
        step();
        #2 rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        bus.req = '0;       bus.req_data = '0;   bus.rsp_ready = 1'b1;
        bus15.req = '0;     bus15.req_data = '0; bus15.rsp_ready = 1'b1;
        step();
        step();
        checks++; if (bus.grant !== 4'b0000) begin errors++; $display("FAIL reset_grant: got %b expected 0000", bus.grant); end
        checks++; if (bus.unit_start !== 1'b0) begin errors++; $display("FAIL reset_unit_start: got %b expected 0", bus.unit_start); end
        checks++; if (bus.unit_in !== 5'd0) begin errors++; $display("FAIL reset_unit_in: got %0d expected 0", bus.unit_in); end
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", bus.rsp_valid); end
        checks++; if (bus.rsp_id !== 2'd0) begin errors++; $display("FAIL reset_rsp_id: got %0d expected 0", bus.rsp_id); end
        checks++; if (bus.rsp_data !== 5'd0) begin errors++; $display("FAIL reset_rsp_data: got %0d expected 0", bus.rsp_data); end
        checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state_dbg); end
        checks++; if (state15_dbg !== 2'd0) begin errors++; $display("FAIL reset_state15: got %0d expected 0", state15_dbg); end
        #3 rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++; if (bus.grant !== 4'b0000) begin errors++; $display("FAIL idle_no_grant: got %b expected 0000", bus.grant); end
            checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL idle_state: got %0d expected 0", state_dbg); end
        end
    endtask

    task automatic test_single;
        bus.req = 4'b0100;
        bus.req_data = {5'd0, 5'd7, 5'd0, 5'd0};
        step();
        bus.req = '0;
        checks++; if (bus.grant !== 4'b0100) begin errors++; $display("FAIL single_grant: got %b expected 0100", bus.grant); end
        checks++; if (bus.unit_start !== 1'b1) begin errors++; $display("FAIL single_unit_start: got %b expected 1", bus.unit_start); end
        checks++; if (bus.unit_in !== 5'd7) begin errors++; $display("FAIL single_unit_in: got %0d expected 7", bus.unit_in); end
        checks++; if (state_dbg !== 2'd1) begin errors++; $display("FAIL single_state_busy: got %0d expected 1", state_dbg); end
        step();
        checks++; if (bus.grant !== 4'b0000) begin errors++; $display("FAIL single_grant_pulse: got %b expected 0000", bus.grant); end
        checks++; if (bus.unit_start !== 1'b0) begin errors++; $display("FAIL single_start_pulse: got %b expected 0", bus.unit_start); end
        checks++; if (bus.unit_in !== 5'd7) begin errors++; $display("FAIL single_unit_in_hold: got %0d expected 7", bus.unit_in); end
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid: got %b expected 0", bus.rsp_valid); end
        step();
        checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL single_rsp_valid: got %b expected 1", bus.rsp_valid); end
        checks++; if (bus.rsp_id !== 2'd2) begin errors++; $display("FAIL single_rsp_id: got %0d expected 2", bus.rsp_id); end
        checks++; if (bus.rsp_data !== 5'd8) begin errors++; $display("FAIL single_rsp_data: got %0d expected 8", bus.rsp_data); end
        checks++; if (bus.unit_in !== 5'd0) begin errors++; $display("FAIL single_unit_in_zero: got %0d expected 0", bus.unit_in); end
        step();
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL single_rsp_drop: got %b expected 0", bus.rsp_valid); end
        checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL single_back_idle: got %0d expected 0", state_dbg); end
    endtask

    task automatic test_round_robin;
        logic [3:0] exp_g;
        logic [4:0] exp_d;
        do_reset();
        bus.req = 4'b1111;
        bus.req_data = {5'd13, 5'd12, 5'd11, 5'd10};
        step();
        for (int g = 0; g < 5; g++) begin
            exp_g = 4'b0001 << (g % 4);
            exp_d = 5'(10 + (g % 4));
            checks++; if (bus.grant !== exp_g) begin errors++; $display("FAIL rr_grant[%0d]: got %b expected %b", g, bus.grant, exp_g); end
            checks++; if (bus.unit_in !== exp_d) begin errors++; $display("FAIL rr_unit_in[%0d]: got %0d expected %0d", g, bus.unit_in, exp_d); end
            step();
            checks++; if (bus.grant !== 4'b0000) begin errors++; $display("FAIL rr_gap1[%0d]: got %b expected 0000", g, bus.grant); end
            step();
            checks++; if (bus.grant !== 4'b0000) begin errors++; $display("FAIL rr_gap2[%0d]: got %b expected 0000", g, bus.grant); end
            checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL rr_valid[%0d]: got %b expected 1", g, bus.rsp_valid); end
            checks++; if (bus.rsp_id !== 2'(g % 4)) begin errors++; $display("FAIL rr_id[%0d]: got %0d expected %0d", g, bus.rsp_id, g % 4); end
            checks++; if (bus.rsp_data !== 5'(exp_d + 5'd1)) begin errors++; $display("FAIL rr_data[%0d]: got %0d expected %0d", g, bus.rsp_data, exp_d + 5'd1); end
            if (g == 4) bus.req = '0;
            step();
        end
        checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL rr_end_idle: got %0d expected 0", state_dbg); end
    endtask

    task automatic test_stall;
        bus.rsp_ready = 1'b0;
        bus.req = 4'b0011;
        bus.req_data = {5'd0, 5'd0, 5'd20, 5'd3};
        step();
        checks++; if (bus.grant !== 4'b0010) begin errors++; $display("FAIL stall_first_grant: got %b expected 0010", bus.grant); end
        step();
        step();
        for (int c = 0; c < 5; c++) begin
            checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d]: got %b expected 1", c, bus.rsp_valid); end
            checks++; if (bus.rsp_id !== 2'd1) begin errors++; $display("FAIL stall_id[%0d]: got %0d expected 1", c, bus.rsp_id); end
            checks++; if (bus.rsp_data !== 5'd21) begin errors++; $display("FAIL stall_data[%0d]: got %0d expected 21", c, bus.rsp_data); end
            checks++; if ((bus.grant !== 4'b0000) || (bus.unit_start !== 1'b0)) begin errors++; $display("FAIL stall_no_grant[%0d]: got %b/%b expected 0000/0", c, bus.grant, bus.unit_start); end
            step();
        end
        bus.rsp_ready = 1'b1;
        step();
        bus.req = '0;
        checks++; if (bus.grant !== 4'b0001) begin errors++; $display("FAIL stall_release_grant: got %b expected 0001", bus.grant); end
        checks++; if (bus.unit_in !== 5'd3) begin errors++; $display("FAIL stall_release_operand: got %0d expected 3", bus.unit_in); end
        step();
        step();
        checks++; if (bus.rsp_id !== 2'd0) begin errors++; $display("FAIL stall_second_id: got %0d expected 0", bus.rsp_id); end
        checks++; if (bus.rsp_data !== 5'd4) begin errors++; $display("FAIL stall_second_data: got %0d expected 4", bus.rsp_data); end
        step();
    endtask

    task automatic test_wrap;
        bus.req = 4'b0001;
        bus.req_data = {5'd0, 5'd0, 5'd0, 5'd31};
        step();
        bus.req = '0;
        checks++; if (bus.grant !== 4'b0001) begin errors++; $display("FAIL wrap_grant: got %b expected 0001", bus.grant); end
        step();
        step();
        checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL wrap_valid: got %b expected 1", bus.rsp_valid); end
        checks++; if (bus.rsp_data !== 5'd0) begin errors++; $display("FAIL wrap_data: got %0d expected 0", bus.rsp_data); end
        step();
    endtask

    task automatic test_latency15;
        bus15.req = 4'b0100;
        bus15.req_data = {5'd0, 5'd9, 5'd0, 5'd0};
        step();
        bus15.req = '0;
        checks++; if (bus15.grant !== 4'b0100) begin errors++; $display("FAIL lat15_grant: got %b expected 0100", bus15.grant); end
        checks++; if (bus15.unit_start !== 1'b1) begin errors++; $display("FAIL lat15_start: got %b expected 1", bus15.unit_start); end
        for (int c = 2; c <= 15; c++) begin
            step();
            checks++; if (bus15.rsp_valid !== 1'b0) begin errors++; $display("FAIL lat15_early[%0d]: got %b expected 0", c, bus15.rsp_valid); end
        end
        step();
        checks++; if (bus15.rsp_valid !== 1'b1) begin errors++; $display("FAIL lat15_valid: got %b expected 1", bus15.rsp_valid); end
        checks++; if (bus15.rsp_id !== 2'd2) begin errors++; $display("FAIL lat15_id: got %0d expected 2", bus15.rsp_id); end
        checks++; if (bus15.rsp_data !== 5'd10) begin errors++; $display("FAIL lat15_data: got %0d expected 10", bus15.rsp_data); end
        step();
        checks++; if (state15_dbg !== 2'd0) begin errors++; $display("FAIL lat15_idle: got %0d expected 0", state15_dbg); end
    endtask

    task automatic test_reset_mid;
        bus.req = 4'b0001;
        bus.req_data = {5'd0, 5'd0, 5'd0, 5'd5};
        step();
        bus.req = '0;
        checks++; if (bus.grant !== 4'b0001) begin errors++; $display("FAIL mid_grant: got %b expected 0001", bus.grant); end
        step();
        checks++; if (state_dbg !== 2'd1) begin errors++; $display("FAIL mid_busy2: got %0d expected 1", state_dbg); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL mid_async_state: got %0d expected 0", state_dbg); end
        checks++; if (bus.unit_in !== 5'd0) begin errors++; $display("FAIL mid_async_unit_in: got %0d expected 0", bus.unit_in); end
        step();
        step();
        #2 rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            checks++; if ((bus.rsp_valid !== 1'b0) || (bus.grant !== 4'b0000)) begin errors++; $display("FAIL mid_dropped[%0d]: got %b/%b expected 0/0000", c, bus.rsp_valid, bus.grant); end
        end
        bus.req = 4'b0001;
        bus.req_data = {5'd0, 5'd0, 5'd0, 5'd12};
        step();
        bus.req = '0;
        checks++; if (bus.grant !== 4'b0001) begin errors++; $display("FAIL mid_regrant: got %b expected 0001", bus.grant); end
        step();
        step();
        checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL mid_rsp_valid: got %b expected 1", bus.rsp_valid); end
        checks++; if (bus.rsp_id !== 2'd0) begin errors++; $display("FAIL mid_rsp_id: got %0d expected 0", bus.rsp_id); end
        checks++; if (bus.rsp_data !== 5'd13) begin errors++; $display("FAIL mid_rsp_data: got %0d expected 13", bus.rsp_data); end
        step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_stall();
        test_wrap();
        test_latency15();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/shared_unit_arbiter.md
# shared_unit_arbiter

Round-robin arbiter and sequencer that shares one fixed-latency compute unit (an increment or bus-replicate child) among NREQ requesters. It accepts one request at a time, drives the unit's input, and waits the unit's latency. It then captures the unit's result and returns it to the winner over a valid/ready response port. It sits in the parent, between the requesting logic and the single shared child instance.

## Interface
- NREQ, 4: number of requesters, 2..8.
- WIDTH, 5: data width of unit input/output.
- LATENCY, 2: cycles from unit_start to valid unit_out, 1..15.

- _clock  in  1  single clock, all state on rising edge.
- _reset  in  1  asynchronous, active-low reset.
- req  in  NREQ  per-requester request level.
- req_data  in  NREQ*WIDTH  requester k operand at bits [k*WIDTH +: WIDTH].
- grant  out  NREQ  one-hot, one-cycle pulse: request accepted.
- unit_start  out  1  one-cycle pulse starting the shared unit.
- unit_in  out  WIDTH  operand to shared unit, held stable for the whole BUSY state.
- unit_out  in  WIDTH  result from shared unit.
- rsp_valid  out  1  response available.
- rsp_id  out  log2(NREQ) (min 1)  index of requester owning response.
- rsp_data  out  WIDTH  captured unit result.
- rsp_ready  in  1  consumer accepts response.

## Operation
- States: IDLE, BUSY, RESP. Reset enters IDLE.
- Arbitration happens at a clock edge while in IDLE, or in RESP when the response is accepted that edge.
  - Winner: first k with req[k]=1, scanning ptr, ptr+1, … mod NREQ.
  - The edge latches the winner id and req_data slice, and sets ptr = (winner+1) mod NREQ.
  - The next state is BUSY.
  - With no request pending, the state goes to (or stays in) IDLE and ptr is unchanged.
- BUSY:
  - First cycle: grant[id]=1 and unit_start=1.
  - unit_in = latched operand for all BUSY cycles; it is 0 outside BUSY.
  - A down-counter loaded with LATENCY decrements each BUSY cycle.
  - On the edge ending the LATENCY-th BUSY cycle: capture unit_out into rsp_data, set rsp_id = id, go to RESP.
- RESP:
  - rsp_valid=1; rsp_data and rsp_id are held stable until accepted.
  - Acceptance: rsp_valid & rsp_ready at an edge. It re-arbitrates on the same edge (RESP→BUSY back-to-back), otherwise the state goes to IDLE.
- Requests are levels sampled only at arbitration edges. A requester holding req after its grant is treated as a new request, subject to round-robin.
- The block performs no arithmetic; WIDTH overflow behaviour belongs to the unit and is passed through unchanged.
- Reset values: grant=0, unit_start=0, unit_in=0, rsp_valid=0, rsp_id=0, rsp_data=0, ptr=0, counter=0, state IDLE.
- Reset mid-operation:
  - An in-flight transaction is dropped and no response is produced.
  - The requester must re-request after reset deasserts.

## Timing
- Request to grant: req sampled at edge E0; grant/unit_start high in cycle E0+1.
- Request to response: rsp_valid high from cycle E0+LATENCY+1.
- Back-to-back throughput: one transaction per LATENCY+1 cycles when rsp_ready stays high and requests are pending.
- rsp_ready low stalls in RESP indefinitely. No grant and no unit_start are issued while stalled.
- grant and unit_start are never high outside the first BUSY cycle. Across NREQ simultaneous held requests, each requester is granted exactly once per NREQ grants.

## Test plan
- Reset → all outputs 0 and state IDLE. Deassert _reset asynchronously mid-cycle → no grant until req is seen.
- NREQ=4, WIDTH=5, LATENCY=2, bench unit = unit_in+1 (mod 32). req=0100, req_data[2]=7 at E0 → grant=0100 and unit_start in E0+1; rsp_valid, rsp_id=2, rsp_data=8 in E0+3.
- req=1111 held, rsp_ready=1 → grant sequence 0001, 0010, 0100, 1000, 0001, one grant every 3 cycles.
- rsp_ready=0 for 5 cycles with req=0011 pending → rsp_valid, rsp_id and rsp_data stable, no grant. Then rsp_ready=1 → same-edge grant to the next requester in round-robin order.
- Operand 31 → rsp_data=0 (unit wrap passed through). Then LATENCY=15 → response 16 cycles after E0.
- Assert _reset in the second BUSY cycle → rsp_valid never rises. After release with req=0001 → normal response, rsp_id=0.
